// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Bundles the request, external-multiplier, HI/LO write and result signals
//   of the multiply/divide controller.
//
//   Request   : req_valid, req_op[1:0], req_a[31:0], req_b[31:0], req_ready
//   Multiplier: mul_valid, mul_a[31:0], mul_b[31:0], mul_done, mul_c[63:0]
//   HI/LO port: hilo_we, hilo_wsel (0 LO, 1 HI), hilo_wdata[31:0]
//   Result    : hi[31:0], lo[31:0], busy, resp_valid
//
//   slave  : the controller's view.
//   master : the view of the CPU pipeline and the external multiplier.
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;

    logic        mul_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [63:0] mul_c;

    logic        hilo_we;
    logic        hilo_wsel;
    logic [31:0] hilo_wdata;

    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        resp_valid;

    modport slave (
        input  req_valid, req_op, req_a, req_b, mul_done, mul_c,
               hilo_we, hilo_wsel, hilo_wdata,
        output req_ready, mul_valid, mul_a, mul_b, hi, lo, busy, resp_valid
    );

    modport master (
        output req_valid, req_op, req_a, req_b, mul_done, mul_c,
               hilo_we, hilo_wsel, hilo_wdata,
        input  req_ready, mul_valid, mul_a, mul_b, hi, lo, busy, resp_valid
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   MIPS-style HI/LO multiply/divide controller. Multiplies run on an external
//   unsigned multiplier (operand magnitudes out, 64-bit product back); divides
//   run on an internal radix-2 restoring divider, one quotient bit per cycle.
//   Signs are stripped on accept and re-applied in the single FIX cycle.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-high reset
//     bus   : muldiv_ctrl_if.slave (request, multiplier, HI/LO write, result)
//
//   Parameter:
//     DIV_ZERO_FAST : 1 = divide by zero bypasses DIV_RUN and goes to FIX.
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter bit DIV_ZERO_FAST = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_ISSUE,
        MUL_WAIT,
        DIV_RUN,
        FIX
    } state_t;

    state_t      state_q, state_d;
    logic        is_div_q;
    logic        neg_a_q, neg_b_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic [31:0] raw_a_q;
    logic        zero_div_q;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prod_q;
    logic [31:0] hi_q, lo_q;
    logic        resp_q;

    logic        req_ready;
    logic        accept;
    logic        signed_op;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_shift, diff;
    logic [63:0] prod_res;
    logic [31:0] quo_res, rem_res;
    logic [31:0] fix_hi, fix_lo;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = bus.req_valid && req_ready;

    // Sign handling only for MULT/DIV (op bit 0 clear).
    assign signed_op = ~bus.req_op[0];
    assign neg_a     = signed_op & bus.req_a[31];
    assign neg_b     = signed_op & bus.req_b[31];
    assign mag_a     = neg_a ? (32'd0 - bus.req_a) : bus.req_a;
    assign mag_b     = neg_b ? (32'd0 - bus.req_b) : bus.req_b;

    // Restoring step: shift the next dividend bit into the 33-bit partial
    // remainder and subtract the divisor; a clear sign bit means it fits.
    // The remainder stays below the divisor, so 32 bits hold it between steps.
    assign rem_shift = {rem_q, quo_q[31]};
    assign diff      = rem_shift - {1'b0, mag_b_q};
    assign cnt_d     = cnt_q + 6'd1;

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
        if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    assign prod_res = (neg_a_q ^ neg_b_q) ? (64'd0 - prod_q) : prod_q;
    assign quo_res  = (neg_a_q ^ neg_b_q) ? (32'd0 - quo_q) : quo_q;
    assign rem_res  = neg_a_q ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        fix_hi = prod_res[63:32];
        fix_lo = prod_res[31:0];
        if (is_div_q) begin
            if (zero_div_q) begin
                fix_hi = raw_a_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_res;
                fix_lo = quo_res;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_op[1])
                        state_d = MUL_ISSUE;
                    else if (DIV_ZERO_FAST && (bus.req_b == 32'd0))
                        state_d = FIX;
                    else
                        state_d = DIV_RUN;
                end
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT:  if (bus.mul_done) state_d = FIX;
            DIV_RUN:   if (cnt_q == 6'd31) state_d = FIX;
            FIX:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            raw_a_q    <= '0;
            zero_div_q <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            resp_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            resp_q  <= (state_q == FIX);

            if (accept) begin
                is_div_q   <= bus.req_op[1];
                neg_a_q    <= neg_a;
                neg_b_q    <= neg_b;
                mag_a_q    <= mag_a;
                mag_b_q    <= mag_b;
                raw_a_q    <= bus.req_a;
                zero_div_q <= (bus.req_b == 32'd0);
                rem_q      <= '0;
                quo_q      <= mag_a;
                cnt_q      <= '0;
            end else if (state_q == DIV_RUN) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_d;
            end

            if ((state_q == MUL_WAIT) && bus.mul_done)
                prod_q <= bus.mul_c;

            // MTHI/MTLO only lands in IDLE; a result in FIX overwrites both.
            if (state_q == FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if ((state_q == IDLE) && bus.hilo_we) begin
                if (bus.hilo_wsel)
                    hi_q <= bus.hilo_wdata;
                else
                    lo_q <= bus.hilo_wdata;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mul_valid  = (state_q == MUL_ISSUE);
    assign bus.mul_a      = mag_a_q;
    assign bus.mul_b      = mag_b_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.resp_valid = resp_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed bench for muldiv_ctrl: a table of operations with hand-computed
//   HI/LO and latency, then hand-written sequences for reset, MTHI/MTLO
//   interplay, a slow multiplier, ignored requests and the slow zero-divide.
//   u_dut uses the default DIV_ZERO_FAST=1; u_slow uses DIV_ZERO_FAST=0.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   mul_lat = 1;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus();
    muldiv_ctrl_if bus_s();

    muldiv_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    muldiv_ctrl #(.DIV_ZERO_FAST(1'b0)) u_slow (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    // External unsigned multiplier: raises mul_done mul_lat cycles after the
    // cycle in which mul_valid was high.
    initial begin : mul_model
        int          cnt;
        logic [63:0] held;
        cnt          = 0;
        held         = '0;
        bus.mul_done = 1'b0;
        bus.mul_c    = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_c    = held;
                end
            end
            if (bus.mul_valid) begin
                cnt  = mul_lat;
                held = 64'(bus.mul_a) * 64'(bus.mul_b);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input logic sel, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.hilo_we    = we;
        bus.hilo_wsel  = sel;
        bus.hilo_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.hilo_we   = 1'b0;
    endtask

    task automatic mt(input logic sel, input logic [31:0] wd);
        @(negedge clk);
        bus.hilo_we    = 1'b1;
        bus.hilo_wsel  = sel;
        bus.hilo_wdata = wd;
        @(posedge clk);
        #1;
        bus.hilo_we = 1'b0;
    endtask

    // Accepts one operation, then watches cycles 1..N until resp_valid.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic we, input logic sel, input logic [31:0] wd,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat);
        int          lat;
        int          mv;
        int          bz;
        logic        got;
        logic [31:0] hi1;
        logic [31:0] lo1;
        accept(op, a, b, we, sel, wd);
        lat = 0; mv = 0; bz = 0; got = 1'b0; hi1 = '0; lo1 = '0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                hi1 = bus.hi;
                lo1 = bus.lo;
            end
            mv += int'(bus.mul_valid);
            bz += int'(bus.busy);
            got = bus.resp_valid;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
        check({name, " mul_valid cycles"}, 64'(mv), op[1] ? 64'd0 : 64'd1);
        check({name, " busy cycles"}, 64'(bz), 64'(exp_lat - 1));
        if (we)
            check({name, " coincident mthi/mtlo"}, 64'(sel ? hi1 : lo1), 64'(wd));
        @(negedge clk);
        check({name, " resp_valid width"}, 64'(bus.resp_valid), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin : main
        int          lat;
        int          nresp;
        logic        got;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4};
        vecs[1]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4};
        vecs[2]  = '{OP_MULT,  32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, 4};
        vecs[3]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 4};
        vecs[4]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 34};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 34};
        vecs[10] = '{OP_DIVU,  32'd3,        32'd5,        32'h00000003, 32'h00000000, 34};
        vecs[11] = '{OP_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 2};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2};
        vecs[13] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 34};

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.hilo_we = 1'b0; bus.hilo_wsel = 1'b0; bus.hilo_wdata = '0;
        bus_s.req_valid = 1'b0; bus_s.req_op = '0; bus_s.req_a = '0; bus_s.req_b = '0;
        bus_s.hilo_we = 1'b0; bus_s.hilo_wsel = 1'b0; bus_s.hilo_wdata = '0;
        bus_s.mul_done = 1'b0; bus_s.mul_c = '0;

        // Reset takes effect before any clock edge.
        #2;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset req_ready", 64'(bus.req_ready), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset mul_valid", 64'(bus.mul_valid), 64'd0);
        check("reset mul_a", 64'(bus.mul_a), 64'd0);
        check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready after reset", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 32'd0,
                   vecs[i].hi, vecs[i].lo, vecs[i].lat);

        // MULT -3 * 7: magnitudes stay on mul_a/mul_b after completion.
        run_op("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 32'd0,
               32'hFFFFFFFF, 32'hFFFFFFEB, 4);
        check("mult -3*7 mul_a", 64'(bus.mul_a), 64'd3);
        check("mult -3*7 mul_b", 64'(bus.mul_b), 64'd7);

        // Slower multiplier keeps the FSM in MUL_WAIT.
        mul_lat = 3;
        run_op("mult slow mul", OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, 32'd42, 6);
        mul_lat = 1;

        // MTHI on the accept edge lands, then the product overwrites HI/LO.
        run_op("multu+mthi", OP_MULTU, 32'd2, 32'd3, 1'b1, 1'b1, 32'h5555, 32'd0, 32'd6, 4);

        // MTLO/MTHI in IDLE, then an MTHI during DIV_RUN is ignored.
        mt(1'b1, 32'h0000BEEF);
        mt(1'b0, 32'h00001234);
        @(negedge clk);
        check("mthi idle", 64'(bus.hi), 64'h0000BEEF);
        check("mtlo idle", 64'(bus.lo), 64'h00001234);
        accept(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                bus.hilo_we = 1'b1; bus.hilo_wsel = 1'b1; bus.hilo_wdata = 32'h0000ABCD;
            end
            if (lat == 6) bus.hilo_we = 1'b0;
            if (lat == 20) begin
                check("mthi in div_run hi", 64'(bus.hi), 64'h0000BEEF);
                check("mthi in div_run lo", 64'(bus.lo), 64'h00001234);
            end
            got = bus.resp_valid;
        end
        check("mthi in div_run latency", 64'(lat), 64'd34);
        check("mthi in div_run result hi", 64'(bus.hi), 64'd2);
        check("mthi in div_run result lo", 64'(bus.lo), 64'd14);

        // A request while busy is dropped, not queued.
        accept(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
        lat = 0; got = 1'b0; nresp = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 3) begin
                bus.req_valid = 1'b1; bus.req_op = OP_MULT; bus.req_a = 32'd2; bus.req_b = 32'd2;
            end
            if (lat == 6) bus.req_valid = 1'b0;
            nresp += int'(bus.mul_valid);
            got = bus.resp_valid;
        end
        check("busy req latency", 64'(lat), 64'd34);
        check("busy req lo", 64'(bus.lo), 64'd14);
        check("busy req mul_valid cycles", 64'(nresp), 64'd0);
        @(negedge clk);
        check("busy req not queued", 64'(bus.busy), 64'd0);

        // DIVU 5/0 without the fast path: full 32-cycle run.
        @(negedge clk);
        bus_s.req_valid = 1'b1; bus_s.req_op = OP_DIVU; bus_s.req_a = 32'd5; bus_s.req_b = 32'd0;
        @(posedge clk);
        #1;
        bus_s.req_valid = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = bus_s.resp_valid;
        end
        check("slow div0 latency", 64'(lat), 64'd34);
        check("slow div0 hi", 64'(bus_s.hi), 64'd5);
        check("slow div0 lo", 64'(bus_s.lo), 64'hFFFFFFFF);

        // Reset pulsed in cycle 10 of DIV_RUN abandons the divide.
        accept(OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid reset busy", 64'(bus.busy), 64'd0);
        check("mid reset hi", 64'(bus.hi), 64'd0);
        check("mid reset lo", 64'(bus.lo), 64'd0);
        check("mid reset mul_a", 64'(bus.mul_a), 64'd0);
        #1;
        reset = 1'b0;
        #1;
        check("mid reset ready after", 64'(bus.req_ready), 64'd1);
        nresp = 0;
        repeat (40) begin
            @(negedge clk);
            nresp += int'(bus.resp_valid);
        end
        check("mid reset no resp", 64'(nresp), 64'd0);
        check("mid reset hi held", 64'(bus.hi), 64'd0);
        run_op("divu 9/4 after reset", OP_DIVU, 32'd9, 32'd4, 1'b0, 1'b0, 32'd0, 32'd1, 32'd2, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
